pipe_reg_chain: RTL and testbench
=================================

Name: pipe_reg_chain

Overview:
- Parametrised register pipeline: a DEPTH-stage, WIDTH-bit delay line with a valid/ready handshake on each side.
- Per-stage valid tracking lets internal bubbles collapse forward when the output stalls.
- Supports a synchronous flush, selectable data-register reset, and an occupancy count.
- Generalises the single-bit flop experiments into the reusable retiming/buffer stage placed between datapath blocks.

Parameters:
- WIDTH, 8, data bits per stage.
- DEPTH, 4, number of register stages (>=1).
- RST_DATA, 1: 1 = data registers load RST_VAL on reset; 0 = data registers have no reset (valid bits always reset).
- RST_VAL, 0, WIDTH-bit reset value for data registers when RST_DATA=1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- in_valid_i  input  1  upstream offers in_data_i.
- in_data_i  input  WIDTH  upstream data.
- in_ready_o  output  1  pipeline accepts in_data_i this cycle.
- out_valid_o  output  1  out_data_o is valid.
- out_data_o  output  WIDTH  data of the final stage.
- out_ready_i  input  1  downstream accepts out_data_o this cycle.
- flush_i  input  1  synchronous clear of all stage valids.
- count_o  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- State per stage k (0 = input side, DEPTH-1 = output side): vld[k], dat[k].
- Ready chain (combinational):
  - rdy[DEPTH] = out_ready_i.
  - rdy[k] = !vld[k] || rdy[k+1].
  - in_ready_o = rdy[0] && reset && !flush_i.
- Load rules:
  - Stage 0 loads in_data_i when in_valid_i && in_ready_o.
  - Stage k>0 loads dat[k-1] when vld[k-1] && rdy[k].
  - dat[k] changes only on load; otherwise it holds.
- Valid update:
  - vld[k] next = load_k ? 1 : (vld[k] && !rdy[k+1]).
  - Simultaneous drain and refill of the same stage keeps vld=1 and takes the new data.
- Outputs:
  - out_valid_o = vld[DEPTH-1].
  - out_data_o = dat[DEPTH-1].
  - count_o = popcount(vld), registered alongside vld (no combinational path from inputs).
- Latency: an item accepted at edge t into an empty pipe is presented at out_valid_o after edge t+DEPTH-1, i.e. DEPTH cycles from acceptance to output.
- Throughput: 1 item/cycle while out_ready_i=1; no bubble on restart.
- Full: all vld=1 and out_ready_i=0 -> in_ready_o=0. A full pipe with out_ready_i=1 accepts in the same cycle.
- Bubble collapse: while stalled, valid items advance into empty downstream stages each cycle until packed against the output.
- Ordering: strict FIFO; no item duplicated or dropped except by flush/reset.
- Flush (flush_i=1 at an edge):
  - All vld cleared; count_o=0 next cycle.
  - in_ready_o=0 that cycle, so no input is accepted; dat registers are unchanged.
  - Any handshake at the output in that cycle still counts as completed downstream.
- Reset (reset=0 at an edge), highest priority over flush and the handshake:
  - Registered state after the edge: vld=0, count_o=0, out_valid_o=0.
  - dat = RST_VAL if RST_DATA=1, else unchanged (undefined after power-up).
  - in_ready_o=0 combinationally while reset=0.
  - Reset mid-stream discards all held items.
- DEPTH=1: a single stage obeying the same rules; in_ready_o = !vld[0] || out_ready_i.

Test Plan:
- Reset (DEPTH=4, WIDTH=8, RST_VAL=0x5A): reset=0 for 2 edges with in_valid_i=1 -> out_valid_o=0, count_o=0, in_ready_o=0, out_data_o=0x5A; nothing is accepted.
- Streaming: out_ready_i=1, push 0x01..0x0A back-to-back -> in_ready_o stays 1; 0x01 appears 4 cycles after acceptance, then 0x02..0x0A on consecutive cycles; count_o settles at 4.
- Backpressure/full: out_ready_i=0, offer 0xA0..0xA5 -> A0..A3 accepted, in_ready_o=0, count_o=4, out_data_o=0xA0. Then raise out_ready_i -> A0..A3 drained in order one per cycle, A4 accepted in the same cycle out_ready_i rises.
- Bubble collapse: out_ready_i=0, push 0x11, idle 2 cycles, push 0x22 -> items pack to stages 3 and 2, count_o=2, in_ready_o=1. Then out_ready_i=1 -> 0x11 then 0x22 on consecutive cycles.
- Flush: count_o=3, flush_i=1 with in_valid_i=1, in_data_i=0x77 -> in_ready_o=0 that cycle; next cycle count_o=0, out_valid_o=0; 0x77 never appears at the output.
- Reset mid-operation with RST_DATA=0: pipe full, reset=0 for one edge -> out_valid_o=0, count_o=0, out_data_o not checked. After release, push 0x33 -> 0x33 is output 4 cycles later.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage WIDTH-bit register pipeline; an item takes DEPTH cycles from acceptance to output.
// A per-stage ready chain lets held items close up bubbles while the output is stalled.
module pipe_reg_chain #(
  parameter int                WIDTH    = 8,
  parameter int                DEPTH    = 4,
  parameter bit                RST_DATA = 1'b1,
  parameter logic [WIDTH-1:0]  RST_VAL  = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid_i,
  input  logic [WIDTH-1:0]            in_data_i,
  output logic                        in_ready_o,
  output logic                        out_valid_o,
  output logic [WIDTH-1:0]            out_data_o,
  input  logic                        out_ready_i,
  input  logic                        flush_i,
  output logic [$clog2(DEPTH+1)-1:0]  count_o
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] vld_nxt;
  logic [DEPTH-1:0] load;
  logic [DEPTH:0]   rdy;
  logic             chain;
  logic [WIDTH-1:0] dat [DEPTH];
  logic [WIDTH-1:0] src [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_nxt;
  logic             live;

  // Neither reset nor flush may move data, so both gate every stage load.
  assign live = reset && !flush_i;

  // A stage can accept if it is empty or everything downstream of it can move.
  always_comb begin
    rdy   = '0;
    chain = out_ready_i;
    rdy[DEPTH] = chain;
    for (int k = DEPTH-1; k >= 0; k--) begin
      chain  = !vld[k] || chain;
      rdy[k] = chain;
    end
  end

  assign in_ready_o = rdy[0] && live;

  always_comb begin
    load    = '0;
    src[0]  = in_data_i;
    load[0] = in_valid_i && in_ready_o;
    for (int k = 1; k < DEPTH; k++) begin
      src[k]  = dat[k-1];
      load[k] = vld[k-1] && rdy[k] && live;
    end
  end

  always_comb begin
    vld_nxt   = '0;
    count_nxt = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (live) begin
        vld_nxt[k] = load[k] || (vld[k] && !rdy[k+1]);
      end
      count_nxt = count_nxt + CW'(vld_nxt[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld     <= '0;
      count_q <= '0;
    end else begin
      vld     <= vld_nxt;
      count_q <= count_nxt;
    end
  end

  generate
    if (RST_DATA) begin : g_dat_rst
      always_ff @(posedge clk) begin
        if (!reset) begin
          for (int k = 0; k < DEPTH; k++) dat[k] <= RST_VAL;
        end else begin
          for (int k = 0; k < DEPTH; k++) begin
            if (load[k]) dat[k] <= src[k];
          end
        end
      end
    end else begin : g_dat_nrst
      always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (load[k]) dat[k] <= src[k];
        end
      end
    end
  endgenerate

  assign out_valid_o = vld[DEPTH-1];
  assign out_data_o  = dat[DEPTH-1];
  assign count_o     = count_q;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Randomised and directed bench for pipe_reg_chain with a position-based reference model and data scoreboard.
module tb_pipe_reg_chain;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid_i;
  logic [W-1:0] in_data_i;
  logic         in_ready_o;
  logic         out_valid_o;
  logic [W-1:0] out_data_o;
  logic         out_ready_i;
  logic         flush_i;
  logic [2:0]   count_o;

  pipe_reg_chain #(
    .WIDTH(W), .DEPTH(D), .RST_DATA(1'b1), .RST_VAL(8'h5A)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_ready_i(out_ready_i),
    .flush_i(flush_i), .count_o(count_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // Model: stage index of every held item (oldest first) plus the data scoreboard.
  int pos_q[$];
  int exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  bit exp_rdy;
  bit exp_ov;
  int np[$];
  int lim;
  int nxt;

  always @(negedge clk) begin
    if (mon_en) begin
      exp_rdy = ((pos_q.size() < D) || out_ready_i) && reset && !flush_i;
      exp_ov  = 1'b0;
      if (pos_q.size() > 0) exp_ov = (pos_q[0] == D-1);
      chk("in_ready", int'(in_ready_o), int'(exp_rdy));
      chk("out_valid", int'(out_valid_o), int'(exp_ov));
      chk("count", int'(count_o), pos_q.size());

      if (out_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_data: got %0h expected no item at %0t", out_data_o, $time);
        end else begin
          chk("out_data", int'(out_data_o), exp_q[0]);
          if (out_ready_i) void'(exp_q.pop_front());
        end
      end

      // Advance the model across the coming edge.
      if (!reset) begin
        pos_q.delete();
        exp_q.delete();
      end else begin
        np.delete();
        lim = D;
        foreach (pos_q[i]) begin
          if (i == 0 && pos_q[i] == D-1 && out_ready_i) continue;
          nxt = pos_q[i] + 1;
          if (nxt > lim - 1) nxt = lim - 1;
          np.push_back(nxt);
          lim = nxt;
        end
        pos_q = np;
        if (flush_i) begin
          pos_q.delete();
          exp_q.delete();
        end else if (in_valid_i && exp_rdy) begin
          pos_q.push_back(0);
          exp_q.push_back(int'(in_data_i));
        end
      end
    end
  end

  task automatic step(input bit v, input logic [W-1:0] d, input bit ordy,
                      input bit fl, input bit rst, output bit acc);
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = ordy;
    flush_i     = fl;
    reset       = rst;
    #1;
    acc = v && in_ready_o;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit ordy);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, '0, ordy, 1'b0, 1'b1, a);
  endtask

  initial begin
    bit acc;
    int idx;

    in_valid_i  = 1'b1;
    in_data_i   = 8'h99;
    out_ready_i = 1'b0;
    flush_i     = 1'b0;
    reset       = 1'b0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Reset held over a second edge with input offered.
    step(1'b1, 8'h98, 1'b0, 1'b0, 1'b0, acc);
    chk("rst_accept", int'(acc), 0);
    chk("rst_data", int'(out_data_o), 8'h5A);

    // Streaming.
    for (int i = 1; i <= 10; i++) step(1'b1, W'(i), 1'b1, 1'b0, 1'b1, acc);
    idle(6, 1'b1);

    // Backpressure until full, then release.
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 8'hA0 + W'(idx), 1'b0, 1'b0, 1'b1, acc);
      if (acc) idx++;
    end
    chk("bp_accepted", idx, 4);
    chk("bp_head", int'(out_data_o), 8'hA0);
    for (int c = 0; c < 12 && idx < 6; c++) begin
      step(1'b1, 8'hA0 + W'(idx), 1'b1, 1'b0, 1'b1, acc);
      if (acc) idx++;
    end
    chk("bp_resume", idx, 6);
    idle(6, 1'b1);

    // Bubble collapse.
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b1, acc);
    idle(2, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, acc);
    idle(2, 1'b0);
    chk("bubble_count", int'(count_o), 2);
    idle(4, 1'b1);

    // Flush with an offered item.
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, acc);
    step(1'b1, 8'h56, 1'b0, 1'b0, 1'b1, acc);
    step(1'b1, 8'h57, 1'b0, 1'b0, 1'b1, acc);
    step(1'b1, 8'h77, 1'b0, 1'b1, 1'b1, acc);
    chk("flush_accept", int'(acc), 0);
    idle(5, 1'b1);

    // Reset while full.
    for (int i = 0; i < 4; i++) step(1'b1, 8'hC0 + W'(i), 1'b0, 1'b0, 1'b1, acc);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 8'h33, 1'b1, 1'b0, 1'b1, acc);
    idle(6, 1'b1);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, W'($urandom), ($urandom % 3) != 0,
           ($urandom % 40) == 0, ($urandom % 150) != 0, acc);
    end
    idle(8, 1'b1);
    chk("drain_empty", exp_q.size(), 0);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
